// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and serializer state encoding for the data-bus UART.
package uart_pkg;

    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;
    localparam logic [3:0] CTRL_OFF   = 4'h8;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a combinational head; a push while full succeeds only alongside a pop.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/data_bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus, fed by a byte FIFO.
// Zero-wait-state reads; writes to a full FIFO are dropped and raise sticky overflow.
module data_bus_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        busy_o
);
    localparam int            CW     = $clog2(FIFO_DEPTH + 1);
    localparam int            BW     = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] RELOAD = BW'(CLKS_PER_BIT - 1);

    logic          sel;
    logic [3:0]    off;
    logic          wr;
    logic          push_req;
    logic          push_ok;
    logic          clr_ovf;
    logic          pop;
    logic          enable;
    logic          overflow;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          unused_bits;

    assign sel         = ce && (addr[31:4] == BASE_ADDR[31:4]);
    assign off         = {addr[3:2], 2'b00};
    assign wr          = sel && we;
    assign push_req    = wr && (off == TXDATA_OFF);
    assign clr_ovf     = wr && (off == CTRL_OFF) && data_i[1];
    assign unused_bits = ^{addr[1:0], data_i[31:8]};

    // Popping at the last STOP cycle is what makes frames back-to-back.
    assign pop     = enable && !fifo_empty &&
                     ((state == IDLE) || ((state == STOP) && (baud == '0)));
    assign push_ok = push_req && (!fifo_full || pop);
    assign busy_o  = (state != IDLE) || !fifo_empty;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .din   (data_i[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr && (off == CTRL_OFF)) enable <= data_i[0];
            if (push_req && !push_ok)    overflow <= 1'b1;
            else if (clr_ovf)            overflow <= 1'b0;
        end
    end

    always_comb begin
        status                   = '0;
        status[ST_FULL]          = fifo_full;
        status[ST_EMPTY]         = fifo_empty;
        status[ST_BUSY]          = busy_o;
        status[ST_OVF]           = overflow;
        status[ST_CNT_LSB +: 4]  = 4'(fifo_count);
    end

    always_comb begin
        data_o = '0;
        if (sel && !we) begin
            case (off)
                STATUS_OFF: data_o = status;
                CTRL_OFF:   data_o = {31'b0, enable};
                default:    data_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_o      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (pop) begin
                        state     <= START;
                        shift_reg <= fifo_dout;
                        baud      <= RELOAD;
                        tx_o      <= 1'b0;
                    end
                end
                START: begin
                    if (baud == '0) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        baud    <= RELOAD;
                        tx_o    <= shift_reg[0];
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                DATA: begin
                    if (baud == '0) begin
                        baud <= RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                STOP: begin
                    if (baud == '0) begin
                        if (pop) begin
                            state     <= START;
                            shift_reg <= fifo_dout;
                            baud      <= RELOAD;
                            tx_o      <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx_o  <= 1'b1;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_uart_tx.sv
// Directed bench for data_bus_uart_tx with four clocks per serial bit.
module tb_data_bus_uart_tx;
    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        ce     = 1'b0;
    logic        we     = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        tx_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] A_TX   = 32'h0000_1000;
    localparam logic [31:0] A_ST   = 32'h0000_1004;
    localparam logic [31:0] A_CTRL = 32'h0000_1008;
    localparam logic [31:0] A_RSV  = 32'h0000_100C;

    always #5 clk = ~clk;

    data_bus_uart_tx #(
        .BASE_ADDR    (32'h0000_1000),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .data_i (data_i),
        .data_o (data_o),
        .tx_o   (tx_o),
        .busy_o (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one bus write; the write lands on the next rising edge, returns at the following falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; addr = '0; data_i = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = a;
        #1 d = data_o;
        ce = 1'b0; addr = '0;
    endtask

    function automatic logic [9:0] frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    initial begin
        logic [31:0] d;
        logic [9:0]  s2;
        logic [19:0] s3;
        logic [99:0] s5;
        logic [7:0]  exp_bytes [10];
        int          n;
        int          zeros;

        // 1. reset
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd(A_ST, d);   chk("t1_status", d, 32'h0000_0002);
        chk("t1_tx_idle", tx_o, 1'b1);
        chk("t1_busy", busy_o, 1'b0);
        rd(A_CTRL, d); chk("t1_ctrl", d, 32'h0000_0001);
        rd(A_TX, d);   chk("t1_txdata_reads_zero", d, 32'h0);

        // 2. single byte A5, sampled mid-period from edge N+1
        wr(A_TX, 32'h0000_00A5);
        @(negedge clk);
        s2[0] = tx_o;
        for (int k = 1; k < 10; k++) begin
            repeat (4) @(negedge clk);
            s2[k] = tx_o;
        end
        chk("t2_frame_a5", s2, 10'b11_0100_1010);
        repeat (3) @(negedge clk);
        chk("t2_busy_n40", busy_o, 1'b1);
        @(negedge clk);
        chk("t2_busy_n41", busy_o, 1'b0);

        // 3. back-to-back 0x55, 0x0F
        wr(A_TX, 32'h0000_0055);
        wr(A_TX, 32'h0000_000F);
        s3[0] = tx_o;
        rd(A_ST, d);   chk("t3_status_after_pop", d, 32'h0000_0104);
        for (int k = 1; k < 20; k++) begin
            repeat (4) @(negedge clk);
            s3[k] = tx_o;
        end
        chk("t3_frame_55", s3[9:0], 10'b10_1010_1010);
        chk("t3_frame_0f", s3[19:10], 10'b10_0001_1110);
        repeat (4) @(negedge clk);
        chk("t3_busy_done", busy_o, 1'b0);

        // 4. disabled, overfill
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 9; i++) wr(A_TX, 32'h11 * (i + 1));
        rd(A_ST, d);   chk("t4_status_overflow", d, 32'h0000_080D);
        chk("t4_tx_held", tx_o, 1'b1);
        repeat (10) @(negedge clk);
        chk("t4_tx_still_held", tx_o, 1'b1);
        rd(A_CTRL, d); chk("t4_ctrl_disabled", d, 32'h0);
        wr(A_CTRL, 32'h3);
        rd(A_ST, d);   chk("t4_status_cleared", d, 32'h0000_0805);

        // 5. drain with refill and a push-while-full coinciding with a pop
        fork
            begin
                @(negedge clk);
                s5[0] = tx_o;
                for (int k = 1; k < 100; k++) begin
                    repeat (4) @(negedge clk);
                    s5[k] = tx_o;
                end
            end
            begin
                logic [31:0] dw;
                @(negedge clk);
                wr(A_TX, 32'h0000_00C3);
                repeat (38) @(negedge clk);
                rd(A_ST, dw);  chk("t5_full_before", dw, 32'h0000_0805);
                wr(A_TX, 32'h0000_003C);
                rd(A_ST, dw);  chk("t5_full_after", dw, 32'h0000_0805);
            end
        join
        for (int i = 0; i < 8; i++) exp_bytes[i] = 8'(8'h11 * (i + 1));
        exp_bytes[8] = 8'hC3;
        exp_bytes[9] = 8'h3C;
        for (int f = 0; f < 10; f++) chk($sformatf("t5_frame%0d", f), s5[f*10 +: 10], frame(exp_bytes[f]));
        n = 0;
        while (busy_o !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t5_busy_drain", busy_o, 1'b0);
        rd(A_ST, d);   chk("t5_status_empty", d, 32'h0000_0002);
        rd(A_CTRL, d); chk("t5_ctrl_enabled", d, 32'h0000_0001);

        // 6. reserved write, then reset during data bit 3
        wr(A_RSV, 32'hFFFF_FFFF);
        rd(A_RSV, d);  chk("t6_rsv_read", d, 32'h0);
        rd(A_CTRL, d); chk("t6_ctrl_after_rsv", d, 32'h0000_0001);
        wr(A_TX, 32'h0000_0000);
        repeat (18) @(negedge clk);
        chk("t6_bit3_low", tx_o, 1'b0);
        chk("t6_busy_mid", busy_o, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t6_tx_async_high", tx_o, 1'b1);
        chk("t6_busy_async_low", busy_o, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rd(A_ST, d);   chk("t6_status_after_reset", d, 32'h0000_0002);
        zeros = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx_o !== 1'b1) zeros++;
        end
        chk("t6_no_residual_frame", zeros, 0);
        ce = 1'b1; we = 1'b0; addr = 32'h0000_2004;
        #1 chk("t6_unselected_read", data_o, 32'h0);
        ce = 1'b0; addr = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
